hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS image-processing core.
- Generates stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- FlushE drives the active-high CLR input of the ID/EX pipeline register.
- Handles load-use hazards with a configurable multi-cycle bubble count, freezes the pipeline on data-memory wait, flushes on taken branches, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_unit.sv | 121 ++++++++++++
 tb/tb_hazard_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage pipeline.
// Rev 1.0 - load-use bubbles, memory-wait freeze, branch flush, stall counter.
`default_nettype none

module hazard_unit #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int REG_W    = 6
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenD,
  input  logic             MemBusyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  localparam logic [3:0] c_BUB_INIT = 4'(LOAD_LAT - 1);

  state_t           r_state, w_next_state;
  logic [3:0]       r_bub_cnt, w_next_bub;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_lu_hit;
  logic             w_fwd_m_a, w_fwd_w_a, w_fwd_m_b, w_fwd_w_b;

  // Register 0 is hard-wired, so it can never be a hazard or forwarding source.
  assign w_lu_hit = MemtoRegE & RegWriteE & (WriteRegE != '0) &
                    ((WriteRegE == RsD) | (WriteRegE == RtD));

  assign w_fwd_m_a = RegWriteM & (WriteRegM != '0) & (WriteRegM == RsE);
  assign w_fwd_w_a = RegWriteW & (WriteRegW != '0) & (WriteRegW == RsE);
  assign w_fwd_m_b = RegWriteM & (WriteRegM != '0) & (WriteRegM == RtE);
  assign w_fwd_w_b = RegWriteW & (WriteRegW != '0) & (WriteRegW == RtE);

  always_comb begin
    w_next_state = r_state;
    w_next_bub   = r_bub_cnt;
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    ForwardAE    = 2'b00;
    ForwardBE    = 2'b00;
    if (!CLR) begin
      FlushE = 1'b1;
    end else begin
      if (w_fwd_m_a)      ForwardAE = 2'b10;
      else if (w_fwd_w_a) ForwardAE = 2'b01;
      if (w_fwd_m_b)      ForwardBE = 2'b10;
      else if (w_fwd_w_b) ForwardBE = 2'b01;

      if (MemBusyM) begin
        // Whole pipe freezes; bubble sequencing resumes once memory is ready.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (r_state == LU_STALL) begin
        StallF     = 1'b1;
        StallD     = 1'b1;
        FlushE     = 1'b1;
        w_next_bub = r_bub_cnt - 4'd1;
        if (r_bub_cnt == 4'd1) w_next_state = RUN;
      end else if (w_lu_hit) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (LOAD_LAT > 1) begin
          w_next_state = LU_STALL;
          w_next_bub   = c_BUB_INIT;
        end
      end else begin
        // A branch under any stall stays in ID and is re-evaluated later.
        FlushD = BranchTakenD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!CLR) begin
      r_state        <= RUN;
      r_bub_cnt      <= 4'd0;
      r_stall_cycles <= '0;
    end else begin
      r_state   <= w_next_state;
      r_bub_cnt <= w_next_bub;
      if (StallD && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign StallCycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for two hazard_unit configurations
// (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=4) sharing one stimulus stream.
`default_nettype none

module tb_hazard_unit;

  localparam int REG_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             CLR;
  logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenD, MemBusyM;

  logic        sF0, sD0, sE0, sM0, fD0, fE0;
  logic [1:0]  fa0, fb0;
  logic [15:0] cnt0;
  logic        sF1, sD1, sE1, sM1, fD1, fE1;
  logic [1:0]  fa1, fb1;
  logic [3:0]  cnt1;

  hazard_unit #(.LOAD_LAT(1), .CNT_W(16), .REG_W(REG_W)) u_l1 (
    .clk(clk), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenD(BranchTakenD), .MemBusyM(MemBusyM),
    .StallF(sF0), .StallD(sD0), .StallE(sE0), .StallM(sM0),
    .FlushD(fD0), .FlushE(fE0), .ForwardAE(fa0), .ForwardBE(fb0),
    .StallCycles(cnt0)
  );

  hazard_unit #(.LOAD_LAT(3), .CNT_W(4), .REG_W(REG_W)) u_l3 (
    .clk(clk), .CLR(CLR), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenD(BranchTakenD), .MemBusyM(MemBusyM),
    .StallF(sF1), .StallD(sD1), .StallE(sE1), .StallM(sM1),
    .FlushD(fD1), .FlushE(fE1), .ForwardAE(fa1), .ForwardBE(fb1),
    .StallCycles(cnt1)
  );

  typedef struct packed {
    logic        sF, sD, sE, sM, fD, fE;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t g0, g1;
  assign g0 = {sF0, sD0, sE0, sM0, fD0, fE0, fa0, fb0, cnt0};
  assign g1 = {sF1, sD1, sE1, sM1, fD1, fE1, fa1, fb1, 12'd0, cnt1};

  int total  = 0;
  int passed = 0;

  // Reference model state, one slot per configuration.
  logic        m_lu[2];
  int          m_bub[2];
  int          m_cnt[2];
  int          lat[2]  = '{1, 3};
  int          cmax[2] = '{65535, 15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == rs) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_out(input int k);
    exp_t e;
    logic hit;
    e = '0;
    e.cnt = 16'(m_cnt[k]);
    hit = MemtoRegE && RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    if (!CLR) begin
      e.fE = 1'b1;
      return e;
    end
    e.fa = fwd_sel(RsE);
    e.fb = fwd_sel(RtE);
    if (MemBusyM) begin
      e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1;
    end else if (m_lu[k] || hit) begin
      e.sF = 1; e.sD = 1; e.fE = 1;
    end else begin
      e.fD = BranchTakenD;
    end
    return e;
  endfunction

  task automatic model_step(input int k, input exp_t e);
    logic hit;
    hit = MemtoRegE && RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    if (!CLR) begin
      m_lu[k] = 0; m_bub[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (e.sD && m_cnt[k] < cmax[k]) m_cnt[k]++;
    if (MemBusyM) return;
    if (m_lu[k]) begin
      if (m_bub[k] == 1) m_lu[k] = 0;
      m_bub[k]--;
    end else if (hit && lat[k] > 1) begin
      m_lu[k] = 1; m_bub[k] = lat[k] - 1;
    end
  endtask

  task automatic compare(input string d, input exp_t g, input exp_t e);
    check({d, " StallF"},      32'(g.sF),  32'(e.sF));
    check({d, " StallD"},      32'(g.sD),  32'(e.sD));
    check({d, " StallE"},      32'(g.sE),  32'(e.sE));
    check({d, " StallM"},      32'(g.sM),  32'(e.sM));
    check({d, " FlushD"},      32'(g.fD),  32'(e.fD));
    check({d, " FlushE"},      32'(g.fE),  32'(e.fE));
    check({d, " ForwardAE"},   32'(g.fa),  32'(e.fa));
    check({d, " ForwardBE"},   32'(g.fb),  32'(e.fb));
    check({d, " StallCycles"}, 32'(g.cnt), 32'(e.cnt));
  endtask

  // Inputs are stable here; outputs are sampled on the falling edge.
  task automatic step();
    exp_t e0, e1;
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(negedge clk);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    compare("lat1", g0, e0);
    compare("lat3", g1, e1);
    model_step(0, e0);
    model_step(1, e1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CLR = 1; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; BranchTakenD = 0; MemBusyM = 0;
  endtask

  task automatic load_hit(input logic [REG_W-1:0] r);
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = r; RsD = r;
  endtask

  initial begin
    idle();
    CLR = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_lu[k] = 0; m_bub[k] = 0; m_cnt[k] = 0;
    end

    step();                       // reset held: forced outputs, counter cleared
    idle(); step();

    load_hit(5); step();          // load-use: 1 bubble vs 3 bubbles
    idle(); repeat (3) step();

    RegWriteM = 1; WriteRegM = 7; RegWriteW = 1; WriteRegW = 7; RsE = 7; RtE = 0;
    step();
    RegWriteM = 0; step();
    RtE = 7; RegWriteM = 1; WriteRegM = 3; step();

    idle(); RegWriteM = 1; RegWriteW = 1; RsE = 0; RtE = 0; step();
    idle(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 0; RsD = 0; step();

    idle(); BranchTakenD = 1; step();
    load_hit(9); RtD = 9; RsD = 2; step();
    idle(); BranchTakenD = 1; repeat (3) step();

    idle(); load_hit(4); step();  // memory wait inside the bubble sequence
    idle(); MemBusyM = 1; repeat (2) step();
    idle(); repeat (3) step();

    load_hit(6); step();          // reset aborts a stall in progress
    idle(); CLR = 0; step();
    idle(); repeat (2) step();

    MemBusyM = 1; repeat (20) step();  // counter saturation on the 4-bit config
    idle(); step();

    for (int i = 0; i < 60; i++) begin
      CLR          = ($urandom_range(0, 19) != 0);
      RsD          = REG_W'($urandom_range(0, 5));
      RtD          = REG_W'($urandom_range(0, 5));
      RsE          = REG_W'($urandom_range(0, 5));
      RtE          = REG_W'($urandom_range(0, 5));
      WriteRegE    = REG_W'($urandom_range(0, 5));
      WriteRegM    = REG_W'($urandom_range(0, 5));
      WriteRegW    = REG_W'($urandom_range(0, 5));
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      MemtoRegE    = 1'($urandom_range(0, 1));
      BranchTakenD = 1'($urandom_range(0, 1));
      MemBusyM     = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
